seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/cpu_ctrl_pkg.sv | 173 +++++++++++++++++
 rtl/seq_control_unit_if.sv | 50 +++++
 rtl/irq_prio_enc.sv | 28 ++
 rtl/seq_control_unit.sv | 196 +++++++++++++++++++
 tb/tb_seq_control_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the sequencer control unit: FSM states, ALU op codes,
// opcode field constants and the instruction decode helpers.
// Purely declarative: no ports, no latency, no backpressure.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC2     = 4'd3,
    ST_INT_ENTER = 4'd4,
    ST_INT_VEC   = 4'd5,
    ST_HALT      = 4'd6,
    ST_TRAP      = 4'd7
  } state_e;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_PASS = 4'd8,
    ALU_INC  = 4'd9,
    ALU_DEC  = 4'd10,
    ALU_NOT  = 4'd11
  } alu_op_e;

  // Where the FSM goes after DECODE.
  typedef enum logic [1:0] {
    NX_IDLE  = 2'd0,
    NX_EXEC2 = 2'd1,
    NX_HALT  = 2'd2,
    NX_TRAP  = 2'd3
  } next_e;

  // instr[15:12]: three-register ALU ops 1..7 map straight onto alu_op 1..7.
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_EXT   = 4'hF;
  // instr[11:8] when instr[15:12] == OP_EXT.
  localparam logic [3:0] SUB_MOV  = 4'h1;
  localparam logic [3:0] SUB_CMP  = 4'h2;
  localparam logic [3:0] SUB_JMP  = 4'h3;
  localparam logic [3:0] SUB_LDM  = 4'h4;
  localparam logic [3:0] SUB_STM  = 4'h5;
  localparam logic [3:0] SUB_NOT  = 4'h6;
  localparam logic [3:0] SUB_EXT  = 4'hF;
  // instr[7:4] when instr[15:8] == FF.
  localparam logic [3:0] X_LDL    = 4'h1;
  localparam logic [3:0] X_INC    = 4'h4;
  localparam logic [3:0] X_DEC    = 4'h5;
  localparam logic [3:0] X_SYS    = 4'hF;
  // instr[3:0] when instr[15:4] == FFF.
  localparam logic [3:0] SYS_HALT = 4'h0;
  localparam logic [3:0] SYS_RIT  = 4'h7;
  localparam logic [3:0] SYS_NOP  = 4'hF;

  // Controls presented in the DECODE cycle for one instruction word.
  typedef struct packed {
    logic       pc_load;
    logic       mem_wr;
    logic       reg1_rd;
    logic       reg2_rd;
    logic       reg3_wr;
    logic       int_unmask;
    alu_op_e    alu_op;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] r3;
  } ctrl_t;

  // Follow-on state class; anything not listed is an undefined encoding.
  function automatic next_e next_of(input logic [15:0] ins);
    next_e nx;
    nx = NX_TRAP;
    if (ins[15:12] >= OP_ADD && ins[15:12] <= OP_SHL) begin
      nx = NX_IDLE;
    end else if (ins[15:12] == OP_EXT) begin
      case (ins[11:8])
        SUB_MOV, SUB_CMP, SUB_JMP, SUB_STM, SUB_NOT: nx = NX_IDLE;
        SUB_LDM: nx = NX_EXEC2;
        SUB_EXT: begin
          case (ins[7:4])
            X_LDL:        nx = NX_EXEC2;
            X_INC, X_DEC: nx = NX_IDLE;
            X_SYS: begin
              case (ins[3:0])
                SYS_NOP, SYS_RIT: nx = NX_IDLE;
                SYS_HALT:         nx = NX_HALT;
                default:          nx = NX_TRAP;
              endcase
            end
            default: nx = NX_TRAP;
          endcase
        end
        default: nx = NX_TRAP;
      endcase
    end
    return nx;
  endfunction

  // Two-operand forms use [3:0] as the source/address register and [7:4] as
  // the destination (or second source); jmp uses [6:4] as condition bits.
  function automatic ctrl_t decode_instr(input logic [15:0] ins,
                                         input logic eq, input logic gt);
    ctrl_t c;
    c = '0;
    if (ins[15:12] >= OP_ADD && ins[15:12] <= OP_SHL) begin
      c.reg1_rd = 1'b1;
      c.reg2_rd = 1'b1;
      c.reg3_wr = 1'b1;
      c.r1      = ins[11:8];
      c.r2      = ins[7:4];
      c.r3      = ins[3:0];
      c.alu_op  = alu_op_e'(ins[15:12]);
    end else if (ins[15:12] == OP_EXT) begin
      case (ins[11:8])
        SUB_MOV: begin
          c.r1 = ins[3:0]; c.r3 = ins[7:4];
          c.reg1_rd = 1'b1; c.reg3_wr = 1'b1; c.alu_op = ALU_PASS;
        end
        SUB_CMP: begin
          c.r1 = ins[3:0]; c.r2 = ins[7:4];
          c.reg1_rd = 1'b1; c.reg2_rd = 1'b1; c.alu_op = ALU_SUB;
        end
        SUB_JMP: begin
          c.r1 = ins[3:0]; c.reg1_rd = 1'b1; c.alu_op = ALU_PASS;
          c.pc_load = (ins[4] & eq) | (ins[5] & ~gt) | (ins[6] & gt);
        end
        SUB_LDM: begin
          // Address goes out now; the memory write-back happens in EXEC2.
          c.r1 = ins[3:0]; c.r3 = ins[7:4];
          c.reg1_rd = 1'b1; c.alu_op = ALU_PASS;
        end
        SUB_STM: begin
          c.r1 = ins[3:0]; c.r2 = ins[7:4];
          c.reg1_rd = 1'b1; c.reg2_rd = 1'b1; c.mem_wr = 1'b1; c.alu_op = ALU_PASS;
        end
        SUB_NOT: begin
          c.r1 = ins[3:0]; c.r3 = ins[7:4];
          c.reg1_rd = 1'b1; c.reg3_wr = 1'b1; c.alu_op = ALU_NOT;
        end
        SUB_EXT: begin
          case (ins[7:4])
            X_LDL: c.r3 = ins[3:0];
            X_INC: begin
              c.r1 = ins[3:0]; c.r3 = ins[3:0];
              c.reg1_rd = 1'b1; c.reg3_wr = 1'b1; c.alu_op = ALU_INC;
            end
            X_DEC: begin
              c.r1 = ins[3:0]; c.r3 = ins[3:0];
              c.reg1_rd = 1'b1; c.reg3_wr = 1'b1; c.alu_op = ALU_DEC;
            end
            X_SYS: begin
              if (ins[3:0] == SYS_RIT) begin
                c.pc_load    = 1'b1;
                c.int_unmask = 1'b1;
              end
            end
            default: c = '0;
          endcase
        end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// Bundle between the sequencer control unit and its datapath/program memory.
// master = control unit (drives strobes/status), slave = datapath side.
// No storage: latency 0, no backpressure beyond instr_valid/resume levels.
interface seq_control_unit_if #(
  parameter int DATA_W = 16,
  parameter int N_INT  = 4
);
  logic [15:0]       instr;
  logic              instr_valid;
  logic [DATA_W-1:0] flags;
  logic [N_INT-1:0]  irq;
  logic [N_INT-1:0]  irq_mask;
  logic              resume;

  logic              pc_inc;
  logic              pc_load;
  logic              pc_push;
  logic              mem_rd;
  logic              mem_wr;
  logic              reg1_rd;
  logic              reg2_rd;
  logic              reg3_wr;
  logic [3:0]        reg1_addr;
  logic [3:0]        reg2_addr;
  logic [3:0]        reg3_addr;
  logic [3:0]        alu_op;
  logic              int_mask_set;
  logic              int_unmask;
  logic [N_INT-1:0]  int_ack;
  logic [2:0]        int_vec;
  logic              halted;
  logic              trap;
  logic [3:0]        state;

  modport master (
    input  instr, instr_valid, flags, irq, irq_mask, resume,
    output pc_inc, pc_load, pc_push, mem_rd, mem_wr,
           reg1_rd, reg2_rd, reg3_wr, reg1_addr, reg2_addr, reg3_addr,
           alu_op, int_mask_set, int_unmask, int_ack, int_vec,
           halted, trap, state
  );

  modport slave (
    output instr, instr_valid, flags, irq, irq_mask, resume,
    input  pc_inc, pc_load, pc_push, mem_rd, mem_wr,
           reg1_rd, reg2_rd, reg3_wr, reg1_addr, reg2_addr, reg3_addr,
           alu_op, int_mask_set, int_unmask, int_ack, int_vec,
           halted, trap, state
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Combinational, zero latency; no backpressure.
// Ports: req_i (N_INT), onehot_o (N_INT), idx_o (3), any_o (1).
module irq_prio_enc #(
  parameter int N_INT = 4
) (
  input  logic [N_INT-1:0] req_i,
  output logic [N_INT-1:0] onehot_o,
  output logic [2:0]       idx_o,
  output logic             any_o
);

  // Scan high to low so the lowest pending index is the last (winning) write.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = 3'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/seq_control_unit.sv
// Microsequencer: fetch/decode FSM issuing registered datapath strobes and
// vectored interrupt entry. Controls appear the cycle after an instruction
// is accepted; FETCH stalls while instr_valid is low (FETCH_WAIT=1).
// Ports: clk, rst (sync, active-high), bus (seq_control_unit_if.master).
import cpu_ctrl_pkg::*;

module seq_control_unit #(
  parameter int DATA_W     = 16,
  parameter int N_INT      = 4,
  parameter int FETCH_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  seq_control_unit_if.master bus
);

  if (DATA_W < 16) begin : g_bad_data_w
    $error("seq_control_unit: DATA_W must be >= 16");
  end
  if (N_INT < 1 || N_INT > 8) begin : g_bad_n_int
    $error("seq_control_unit: N_INT must be 1..8");
  end

  state_e           state_q;
  logic [15:0]      instr_q;
  logic             pc_inc_q, pc_load_q, pc_push_q, mem_rd_q, mem_wr_q;
  logic             reg1_rd_q, reg2_rd_q, reg3_wr_q;
  logic [3:0]       reg1_addr_q, reg2_addr_q, reg3_addr_q;
  alu_op_e          alu_op_q;
  logic             int_mask_set_q, int_unmask_q;
  logic [N_INT-1:0] int_ack_q;
  logic [2:0]       int_vec_q;
  logic             halted_q, trap_q;

  logic [N_INT-1:0] pending;
  logic [N_INT-1:0] sel_onehot;
  logic [2:0]       sel_idx;
  logic             sel_any;
  ctrl_t            dec_d;
  logic             fetch_ok;
  logic             exec_ldm, exec_ldl;
  logic             flags_unused;

  assign pending = bus.irq & ~bus.irq_mask;

  irq_prio_enc #(.N_INT(N_INT)) u_prio (
    .req_i    (pending),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .any_o    (sel_any)
  );

  // Decode straight off the instruction bus so the controls register on the
  // same edge that accepts the word.
  assign dec_d    = decode_instr(bus.instr, bus.flags[0], bus.flags[1]);
  assign fetch_ok = (FETCH_WAIT == 0) ? 1'b1 : bus.instr_valid;

  // EXEC2 flavour, taken from the latched word while in DECODE.
  assign exec_ldm = (instr_q[15:8] == {OP_EXT, SUB_LDM});
  assign exec_ldl = (instr_q[15:4] == {OP_EXT, SUB_EXT, X_LDL});

  assign flags_unused = ^bus.flags[DATA_W-1:3];

  // Outputs for a state are registered on the edge that enters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      instr_q        <= '0;
      pc_inc_q       <= 1'b0;
      pc_load_q      <= 1'b0;
      pc_push_q      <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      reg1_rd_q      <= 1'b0;
      reg2_rd_q      <= 1'b0;
      reg3_wr_q      <= 1'b0;
      reg1_addr_q    <= '0;
      reg2_addr_q    <= '0;
      reg3_addr_q    <= '0;
      alu_op_q       <= ALU_NONE;
      int_mask_set_q <= 1'b0;
      int_unmask_q   <= 1'b0;
      int_ack_q      <= '0;
      int_vec_q      <= '0;
      halted_q       <= 1'b0;
      trap_q         <= 1'b0;
    end else begin
      pc_inc_q       <= 1'b0;
      pc_load_q      <= 1'b0;
      pc_push_q      <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      reg1_rd_q      <= 1'b0;
      reg2_rd_q      <= 1'b0;
      reg3_wr_q      <= 1'b0;
      alu_op_q       <= ALU_NONE;
      int_mask_set_q <= 1'b0;
      int_unmask_q   <= 1'b0;
      int_ack_q      <= '0;
      int_vec_q      <= '0;

      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;

        ST_FETCH: begin
          if (sel_any && !bus.flags[2]) begin
            // Channel is captured here, so later irq changes cannot move it.
            pc_push_q      <= 1'b1;
            int_mask_set_q <= 1'b1;
            int_ack_q      <= sel_onehot;
            int_vec_q      <= sel_idx;
            state_q        <= ST_INT_ENTER;
          end else if (fetch_ok) begin
            instr_q      <= bus.instr;
            pc_inc_q     <= 1'b1;
            pc_load_q    <= dec_d.pc_load;
            mem_wr_q     <= dec_d.mem_wr;
            reg1_rd_q    <= dec_d.reg1_rd;
            reg2_rd_q    <= dec_d.reg2_rd;
            reg3_wr_q    <= dec_d.reg3_wr;
            int_unmask_q <= dec_d.int_unmask;
            alu_op_q     <= dec_d.alu_op;
            reg1_addr_q  <= dec_d.r1;
            reg2_addr_q  <= dec_d.r2;
            reg3_addr_q  <= dec_d.r3;
            state_q      <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (next_of(instr_q))
            NX_EXEC2: begin
              // ldm writes back memory data; ldl writes the literal word and
              // steps the PC past it.
              reg3_wr_q <= 1'b1;
              mem_rd_q  <= exec_ldm;
              pc_inc_q  <= exec_ldl;
              state_q   <= ST_EXEC2;
            end
            NX_HALT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            NX_TRAP: begin
              trap_q  <= 1'b1;
              state_q <= ST_TRAP;
            end
            default: state_q <= ST_IDLE;
          endcase
        end

        ST_EXEC2: state_q <= ST_IDLE;

        ST_INT_ENTER: begin
          mem_rd_q  <= 1'b1;
          pc_load_q <= 1'b1;
          state_q   <= ST_INT_VEC;
        end

        ST_INT_VEC: state_q <= ST_IDLE;

        ST_HALT: begin
          if (bus.resume) begin
            halted_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        ST_TRAP: state_q <= ST_TRAP;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc_inc       = pc_inc_q;
  assign bus.pc_load      = pc_load_q;
  assign bus.pc_push      = pc_push_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.reg1_rd      = reg1_rd_q;
  assign bus.reg2_rd      = reg2_rd_q;
  assign bus.reg3_wr      = reg3_wr_q;
  assign bus.reg1_addr    = reg1_addr_q;
  assign bus.reg2_addr    = reg2_addr_q;
  assign bus.reg3_addr    = reg3_addr_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.int_mask_set = int_mask_set_q;
  assign bus.int_unmask   = int_unmask_q;
  assign bus.int_ack      = int_ack_q;
  assign bus.int_vec      = int_vec_q;
  assign bus.halted       = halted_q;
  assign bus.trap         = trap_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: hand-computed expectations per cycle.
// Inputs driven 1 ns after the rising edge, outputs sampled at that point.
// All comparisons go through check_eq; summary line at the end.
module tb_seq_control_unit;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_EXEC2 = 4'd3, S_INTENT = 4'd4, S_INTVEC = 4'd5,
                         S_HALT = 4'd6, S_TRAP = 4'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_control_unit_if #(.DATA_W(16), .N_INT(4)) bus ();

  seq_control_unit #(.DATA_W(16), .N_INT(4), .FETCH_WAIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input string tag);
    int n;
    n = 0;
    while (bus.state != S_FETCH && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_reach_fetch"}, 32'(bus.state), 32'(S_FETCH));
  endtask

  // Present one valid word for exactly one FETCH edge.
  task automatic issue(input logic [15:0] w, input logic [15:0] f);
    bus.instr       = w;
    bus.flags       = f;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.flags       = '0;
    bus.irq         = '0;
    bus.irq_mask    = '0;
    bus.resume      = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_state", 32'(bus.state), 32'(S_IDLE));
    check_eq("rst_strobes", 32'({bus.pc_inc, bus.pc_load, bus.pc_push, bus.mem_rd,
                                 bus.mem_wr, bus.reg3_wr, bus.alu_op}), 32'd0);
    check_eq("rst_trap_halt", 32'({bus.trap, bus.halted}), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_to_fetch", 32'(bus.state), 32'(S_FETCH));

    // ADD r3 = r1 + r2; next FETCH 3 cycles after acceptance
    issue(16'h1123, 16'h0000);
    check_eq("add_state", 32'(bus.state), 32'(S_DECODE));
    check_eq("add_addrs", 32'({bus.reg1_addr, bus.reg2_addr, bus.reg3_addr}), 32'h123);
    check_eq("add_ctl", 32'({bus.pc_inc, bus.reg1_rd, bus.reg2_rd, bus.reg3_wr, bus.alu_op}),
             32'({4'b1111, 4'd1}));
    tick();
    check_eq("add_idle", 32'(bus.state), 32'(S_IDLE));
    check_eq("add_strobe_clear", 32'({bus.pc_inc, bus.reg3_wr, bus.alu_op}), 32'd0);
    tick();
    check_eq("add_fetch_n3", 32'(bus.state), 32'(S_FETCH));

    // Fetch stall: three cycles without instr_valid
    bus.instr = 16'h2456;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_state", 32'(bus.state), 32'(S_FETCH));
      check_eq("stall_no_inc", 32'(bus.pc_inc), 32'd0);
    end
    issue(16'h2456, 16'h0000);
    check_eq("stall_accept", 32'({bus.pc_inc, bus.alu_op}), 32'({1'b1, 4'd2}));
    wait_fetch("stall");

    // Interrupt: lowest pending channel of 0110 is 1
    bus.irq = 4'b0110;
    tick();
    check_eq("irq_state", 32'(bus.state), 32'(S_INTENT));
    check_eq("irq_ack", 32'(bus.int_ack), 32'b0010);
    check_eq("irq_vec_push", 32'({bus.int_vec, bus.pc_push, bus.int_mask_set}), 32'({3'd1, 2'b11}));
    bus.irq = 4'b0001;
    #1;
    check_eq("irq_vec_stable", 32'(bus.int_vec), 32'd1);
    bus.irq = 4'b0000;
    tick();
    check_eq("irq_vecstate", 32'(bus.state), 32'(S_INTVEC));
    check_eq("irq_vec_ctl", 32'({bus.mem_rd, bus.pc_load, bus.pc_push, bus.int_ack}),
             32'({3'b110, 4'b0000}));
    wait_fetch("irq");

    // Global mask (flags[2]) blocks irq; jmp taken on eq
    bus.irq      = 4'b1001;
    bus.irq_mask = 4'b0001;
    issue(16'hF313, 16'h0005);
    check_eq("jmp_eq_state", 32'(bus.state), 32'(S_DECODE));
    check_eq("jmp_eq_ctl", 32'({bus.pc_load, bus.reg1_addr, bus.alu_op}), 32'({1'b1, 4'd3, 4'd8}));
    bus.flags = 16'h0000;
    wait_fetch("jmp_eq");
    // Now unmasked globally: channel 0 masked, channel 3 serviced
    tick();
    check_eq("irq_mask_ack", 32'({bus.int_ack, bus.int_vec}), 32'({4'b1000, 3'd3}));
    bus.irq      = 4'b0000;
    bus.irq_mask = 4'b0000;
    wait_fetch("irq_mask");

    // jmp not taken when eq clear
    issue(16'hF313, 16'h0000);
    check_eq("jmp_ne_ctl", 32'({bus.pc_load, bus.reg1_addr, bus.alu_op}), 32'({1'b0, 4'd3, 4'd8}));
    wait_fetch("jmp_ne");

    // ldm: two-cycle op, FETCH at N+4
    issue(16'hF425, 16'h0000);
    check_eq("ldm_dec", 32'({bus.reg1_rd, bus.mem_rd, bus.reg1_addr, bus.reg3_addr}),
             32'({2'b10, 4'd5, 4'd2}));
    tick();
    check_eq("ldm_exec2", 32'({bus.state, bus.mem_rd, bus.reg3_wr, bus.reg3_addr}),
             32'({S_EXEC2, 2'b11, 4'd2}));
    tick();
    check_eq("ldm_idle", 32'(bus.state), 32'(S_IDLE));
    tick();
    check_eq("ldm_fetch_n4", 32'(bus.state), 32'(S_FETCH));

    // inc r2
    issue(16'hFF42, 16'h0000);
    check_eq("inc_ctl", 32'({bus.alu_op, bus.reg1_addr, bus.reg3_addr, bus.reg3_wr}),
             32'({4'd9, 4'd2, 4'd2, 1'b1}));
    wait_fetch("inc");

    // rit
    issue(16'hFFF7, 16'h0000);
    check_eq("rit_ctl", 32'({bus.pc_load, bus.int_unmask, bus.alu_op}), 32'({2'b11, 4'd0}));
    wait_fetch("rit");

    // halt; irq ignored while halted; resume -> IDLE -> FETCH
    issue(16'hFFF0, 16'h0000);
    tick();
    check_eq("halt_state", 32'({bus.state, bus.halted}), 32'({S_HALT, 1'b1}));
    bus.irq = 4'b0001;
    tick();
    tick();
    check_eq("halt_no_irq", 32'({bus.state, bus.int_ack}), 32'({S_HALT, 4'b0000}));
    bus.irq    = 4'b0000;
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    check_eq("resume_idle", 32'({bus.state, bus.halted}), 32'({S_IDLE, 1'b0}));
    tick();
    check_eq("resume_fetch", 32'(bus.state), 32'(S_FETCH));

    // Undefined opcode -> sticky TRAP until reset
    issue(16'hE000, 16'h0000);
    check_eq("undef_dec_quiet", 32'({bus.reg3_wr, bus.alu_op, bus.trap}), 32'd0);
    tick();
    check_eq("trap_set", 32'({bus.state, bus.trap}), 32'({S_TRAP, 1'b1}));
    for (int i = 0; i < 3; i++) tick();
    check_eq("trap_sticky", 32'({bus.state, bus.trap}), 32'({S_TRAP, 1'b1}));
    rst = 1'b1;
    tick();
    check_eq("trap_rst", 32'({bus.state, bus.trap}), 32'({S_IDLE, 1'b0}));
    rst = 1'b0;
    wait_fetch("post_trap");

    // ldl, then reset in the middle of EXEC2
    issue(16'hFF13, 16'h0000);
    check_eq("ldl_dec", 32'({bus.reg3_addr, bus.reg3_wr}), 32'({4'd3, 1'b0}));
    tick();
    check_eq("ldl_exec2", 32'({bus.state, bus.pc_inc, bus.reg3_wr, bus.mem_rd}),
             32'({S_EXEC2, 3'b110}));
    rst = 1'b1;
    tick();
    check_eq("exec2_rst", 32'({bus.state, bus.pc_inc, bus.reg3_wr, bus.reg3_addr}), 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
